// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot priority ring, registered grant,
// hold timeout and a one-cycle dead gap after every grant.
module ring_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk_2,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic                    timeout
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [NREQ-1:0] r_grant;
  logic [NREQ-1:0] w_grant_nxt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   w_owner_nxt;
  logic [NREQ-1:0] r_prio;
  logic [NREQ-1:0] w_prio_nxt;
  logic [HW-1:0]   r_hcnt;
  logic [HW-1:0]   w_hcnt_nxt;
  logic            r_busy;
  logic            w_busy_nxt;
  logic            r_timeout;
  logic            w_timeout_nxt;

  logic [OW-1:0]   w_pidx;
  logic            w_hit;
  logic [OW-1:0]   w_sel;
  logic [NREQ-1:0] w_sel_oh;
  logic            w_own_req;
  logic            w_hold_max;
  logic [NREQ-1:0] w_rot;

  always_comb begin
    w_pidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_prio[i]) begin
        w_pidx = OW'(i);
      end
    end
  end

  // circular scan starting at the priority holder
  always_comb begin
    logic [OW-1:0] v_idx;
    int            v_j;
    w_hit = 1'b0;
    w_sel = '0;
    v_idx = '0;
    v_j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      v_j   = (int'(w_pidx) + k) % NREQ;
      v_idx = OW'(v_j);
      if (!w_hit && req[v_idx]) begin
        w_hit = 1'b1;
        w_sel = v_idx;
      end
    end
  end

  assign w_sel_oh   = NREQ'(1) << w_sel;
  assign w_own_req  = req[r_owner];
  assign w_hold_max = (r_hcnt == HW'(MAX_HOLD - 1));
  assign w_rot      = {r_grant[NREQ-2:0], r_grant[NREQ-1]};

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_prio_nxt    = r_prio;
    w_hcnt_nxt    = r_hcnt;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      S_IDLE, S_GAP: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
        if (w_hit) begin
          w_grant_nxt = w_sel_oh;
          w_owner_nxt = w_sel;
          w_hcnt_nxt  = '0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!w_own_req || w_hold_max) begin
          w_grant_nxt   = '0;
          w_prio_nxt    = w_rot;
          w_state_nxt   = S_GAP;
          w_timeout_nxt = w_own_req;
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_prio    <= NREQ'(1);
      r_hcnt    <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_prio    <= w_prio_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign grant   = r_grant;
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed scenarios plus a random phase,
// checked every cycle against a behavioural model.
module tb_ring_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk_2 = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         busy;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  ring_rr_arbiter #(.NREQ(N), .MAX_HOLD(MH)) dut (
    .clk_2   (clk_2),
    .reset   (reset),
    .req     (req),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: 0 idle, 1 granted, 2 gap; m_len = cycles the grant has been up
  int m_st    = 0;
  int m_pidx  = 0;
  int m_own   = 0;
  int m_len   = 0;
  bit m_to    = 1'b0;
  bit m_valid = 1'b0;

  always @(posedge clk_2) begin
    if (reset) begin
      m_st = 0; m_pidx = 0; m_own = 0; m_len = 0; m_to = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_to = 1'b0;
      if (m_st == 1) begin
        if (!req[m_own] || m_len == MH) begin
          m_to   = req[m_own];
          m_pidx = (m_own + 1) % N;
          m_st   = 2;
        end else begin
          m_len++;
        end
      end else begin
        m_st = 0;
        for (int k = 0; k < N; k++) begin
          if (m_st == 0 && req[(m_pidx + k) % N]) begin
            m_own = (m_pidx + k) % N;
            m_len = 1;
            m_st  = 1;
          end
        end
      end
    end
  end

  always @(negedge clk_2) begin
    if (m_valid) begin
      chk("m_grant", 32'(grant), (m_st == 1) ? (32'd1 << m_own) : 32'd0);
      chk("m_owner", 32'(owner), 32'(m_own));
      chk("m_busy", 32'(busy), 32'(m_st != 0));
      chk("m_timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_2); #2;
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_2); #2;
  endtask

  initial begin
    logic [N-1:0] pat [5];
    logic [N-1:0] e;
    pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100;
    pat[3] = 4'b1000; pat[4] = 4'b0001;

    req = '0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_grant", 32'(grant), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_to", 32'(timeout), 0);
      chk("idle_owner", 32'(owner), 0);
    end

    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      e = (c % 4 == 3) ? 4'b0000 : pat[c / 4];
      chk("rr_seq", 32'(grant), 32'(e));
      if (c % 4 == 2) req = 4'b1111 & ~pat[c / 4];
      else            req = 4'b1111;
    end

    req = '0;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 18; c++) begin
      step();
      chk("solo_grant", 32'(grant), (c % 9 < 8) ? 32'h4 : 32'h0);
      chk("solo_to", 32'(timeout), (c % 9 == 8) ? 32'h1 : 32'h0);
    end

    req = '0;
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("to_grant", 32'(grant),
          (c < 8) ? 32'h1 : (c == 8) ? 32'h0 : 32'h4);
      if (c == 8) chk("to_pulse", 32'(timeout), 1);
    end

    req = '0;
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("pre_rst_grant", 32'(grant), 32'h2);
    end
    reset = 1'b1;
    step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_to", 32'(timeout), 0);
    reset = 1'b0;
    req = 4'b1110;
    step();
    chk("post_rst_grant", 32'(grant), 32'h2);
    chk("post_rst_owner", 32'(owner), 1);

    req = '0;
    do_reset();
    req = 4'b1000;
    step();
    chk("p3_grant", 32'(grant), 32'h8);
    req = '0;
    step();
    chk("p3_gap", 32'(busy), 1);
    step();
    chk("p3_idle", 32'(busy), 0);
    req = 4'b0011;
    step();
    chk("wrap_grant", 32'(grant), 32'h1);
    chk("wrap_owner", 32'(owner), 0);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      reset = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
